pila_param: RTL

Parametrised hardware return-address stack (LIFO) for the CPU's subroutine call/return path.
- `push` stores the return PC on a call; `pop` supplies the saved PC on a return.
- Generalises the fixed 8-entry, 10-bit stack in width and depth.
- Adds occupancy status, sticky overflow/underflow error flags, simultaneous push+pop (replace top), and a selectable full-stack policy (reject or circular overwrite).
- Sits beside the PC register; `outpop` feeds the next-PC mux.

---
 rtl/pila_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pila_param.sv
// pila_param: parametrised return-address stack (LIFO) for the call/return path.
// A push stores the return PC on a call and a pop hands the saved PC to the
// next-PC mux on a return. The stack supports occupancy status, sticky
// overflow/underflow flags, push+pop as "replace top", and a selectable
// full-stack policy (reject, or circular overwrite of the oldest entry).
module pila_param #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int WRAP  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           inpush,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           outpop,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // DEPTH is a power of two, so an AW-bit pointer wraps modulo DEPTH for free.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    sp;
    logic [AW-1:0]    sp_top;
    logic [AW-1:0]    sp_next;
    logic [CW-1:0]    count_next;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             ov_set;
    logic             un_set;

    assign sp_top = sp - AW'(1);
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));

    // The return address is visible straight from state, so the PC mux can use
    // it in the same cycle pop is asserted.
    assign outpop = empty ? '0 : mem[sp_top];

    // Next-state decode of the push/pop request against the current occupancy.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        sp_next    = sp;
        count_next = count;
        wr_en      = 1'b0;
        wr_addr    = sp;
        ov_set     = 1'b0;
        un_set     = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en      = 1'b1;
                    sp_next    = sp + AW'(1);
                    count_next = count + CW'(1);
                end else if (WRAP != 0) begin
                    // Circular mode: overwrite the oldest slot, occupancy stays at DEPTH.
                    wr_en   = 1'b1;
                    sp_next = sp + AW'(1);
                    ov_set  = 1'b1;
                end else begin
                    ov_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    sp_next    = sp_top;
                    count_next = count - CW'(1);
                end else begin
                    un_set = 1'b1;
                end
            end
            2'b11: begin
                if (!empty) begin
                    // Return immediately followed by a call: rewrite the top in place.
                    wr_en   = 1'b1;
                    wr_addr = sp_top;
                end else begin
                    // Nothing to pop, so the request degrades to a plain push.
                    wr_en      = 1'b1;
                    sp_next    = sp + AW'(1);
                    count_next = count + CW'(1);
                    un_set     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Storage write port; contents survive reset since count gates visibility.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch so it maps onto plain RAM/register-file cells.
        if (wr_en && !reset) begin
            mem[wr_addr] <= inpush;
        end
    end

    // Pointer, occupancy and sticky error flags; a coinciding error beats clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            count     <= count_next;
            overflow  <= (overflow  & ~clr_err) | ov_set;
            underflow <= (underflow & ~clr_err) | un_set;
        end
    end

endmodule
